sha_req_arbiter: RTL

Round-robin scheduler that shares one `sha_256_fsm_3cyc` hash core among `NREQ` requesters. It accepts a 512-bit block from one requester at a time, sequences the core (`sha_start` pulse, wait for `hash_done`), and returns the 256-bit signature to the granted requester. A watchdog aborts jobs whose core never completes. It sits between the message-producing front ends and the core; the output data handler consumes the returned signature.

---
 rtl/sha_req_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sha_req_arbiter.sv
// Round-robin scheduler sharing one SHA-256 core among NREQ requesters, with a
// watchdog that aborts jobs whose core never reports completion.
module sha_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*512-1:0]       req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [255:0]              resp_sig,
    output logic                      resp_err,
    output logic [511:0]              core_data,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [255:0]              core_sig,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StArm, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            hit_q, hit_d;
    logic [511:0]    data_q, data_d;
    logic [255:0]    sig_q, sig_d;
    logic            err_q, err_d;

    logic            pick_found;
    logic [IdW-1:0]  pick_id;
    logic [IdW-1:0]  rr_id;
    int unsigned     rr_idx;

    // Search starts just after the last winner and wraps around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        rr_idx     = 0;
        rr_id      = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            rr_idx = (32'(last_q) + off) % NREQ;
            rr_id  = IdW'(rr_idx);
            if (!pick_found && req_valid[rr_id]) begin
                pick_found = 1'b1;
                pick_id    = rr_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        data_d  = data_q;
        sig_d   = sig_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    last_d  = pick_id;
                    data_d  = req_data[int'(pick_id)*512 +: 512];
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                hit_d   = 1'b0;
                state_d = StArm;
            end
            StArm, StWait: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // hit_q marks the cycle after the counter reached its limit; that
                // cycle is the last one in which completion can still be accepted.
                hit_d = (cnt_q == CntMax);
                if (state_q == StWait && core_done) begin
                    sig_d   = core_sig;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (hit_q) begin
                    sig_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (state_q == StArm && !core_done) begin
                    state_d = StWait;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdW'(NREQ - 1);
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            data_q  <= '0;
            sig_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            data_q  <= data_d;
            sig_q   <= sig_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == StStart) begin
            req_ready[grant_q] = 1'b1;
        end
        if (state_q == StResp) begin
            resp_valid[grant_q] = 1'b1;
        end
    end

    assign core_start = (state_q == StStart);
    assign busy       = (state_q != StIdle);
    assign grant_id   = grant_q;
    assign core_data  = data_q;
    assign resp_sig   = sig_q;
    assign resp_err   = err_q;

endmodule
